// File: rtl/mmul_parallel_package.sv
// rtl/mmul_parallel_package.sv - shared types and default sizes for the parallel job sequencer
package mmul_parallel_package;

    localparam int DEF_N_IN  = 2;
    localparam int DEF_N_OUT = 1;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQUEST   = 2'd1,
        ST_COMPUTE   = 2'd2,
        ST_TERMINATE = 2'd3
    } job_seq_state_t;

endpackage

// File: rtl/mmul_parallel_sticky_flags.sv
// rtl/mmul_parallel_sticky_flags.sv - per-channel sticky flag bank with masked all-set reduction
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of every flag (wins over set)
//   set        : per-channel set strobes, ORed into the flags
//   mask       : channel enables; disabled channels count as already set
//   flags      : raw flag state
//   all_set    : every enabled channel has its flag set
module mmul_parallel_sticky_flags #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] set,
    input  logic [WIDTH-1:0] mask,
    output logic [WIDTH-1:0] flags,
    output logic             all_set
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= '0;
        end else if (clr) begin
            flags <= '0;
        end else begin
            flags <= flags | set;
        end
    end

    assign all_set = &(flags | ~mask);

endmodule

// File: rtl/mmul_parallel_job_seq.sv
// rtl/mmul_parallel_job_seq.sv - iterating job sequencer for input/output streamers and a compute engine
//
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   clear_i                  : synchronous abort back to idle
//   start_i                  : job trigger (only honoured in idle)
//   cnt_limit_i              : iterations minus one, latched at start
//   in_en_i / out_en_i       : channel enable masks, latched at start
//   in_req_o / in_ready_i    : input stream request handshake
//   in_done_i                : input stream finished
//   out_req_o / out_ready_i  : output stream request handshake
//   out_done_i               : output stream finished
//   eng_start_o / eng_done_i : engine tile start pulse / tile finished
//   busy_o                   : job in progress
//   done_evt_o               : one-cycle job completion event
//   iter_o                   : current iteration index
module mmul_parallel_job_seq
    import mmul_parallel_package::*;
#(
    parameter int N_IN  = DEF_N_IN,
    parameter int N_OUT = DEF_N_OUT,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] cnt_limit_i,
    input  logic [N_IN-1:0]  in_en_i,
    input  logic [N_OUT-1:0] out_en_i,
    output logic [N_IN-1:0]  in_req_o,
    input  logic [N_IN-1:0]  in_ready_i,
    input  logic [N_IN-1:0]  in_done_i,
    output logic [N_OUT-1:0] out_req_o,
    input  logic [N_OUT-1:0] out_ready_i,
    input  logic [N_OUT-1:0] out_done_i,
    output logic             eng_start_o,
    input  logic             eng_done_i,
    output logic             busy_o,
    output logic             done_evt_o,
    output logic [CNT_W-1:0] iter_o
);

    job_seq_state_t state_q, state_d;

    logic [CNT_W-1:0] iter_q;
    logic [CNT_W-1:0] limit_q;
    logic [N_IN-1:0]  in_en_q;
    logic [N_OUT-1:0] out_en_q;

    logic flags_clr;
    logic iter_clr;
    logic iter_inc;
    logic job_start;

    logic req_phase;
    logic collect;

    logic [N_IN-1:0]  in_acc;
    logic [N_OUT-1:0] out_acc;
    logic in_acc_all, out_acc_all;
    logic in_dn_all, out_dn_all, eng_dn_all;

    logic [N_IN-1:0]  unused_in_dn;
    logic [N_OUT-1:0] unused_out_dn;
    logic             unused_eng_dn;

    logic accepted_all;
    logic done_all;

    assign req_phase = (state_q == ST_REQUEST);
    // Done strobes are collected from the moment requests go out, so a
    // stream that finishes before the engine is even started is remembered.
    assign collect   = (state_q == ST_REQUEST) || (state_q == ST_COMPUTE);

    assign in_req_o  = req_phase ? (in_en_q & ~in_acc)   : '0;
    assign out_req_o = req_phase ? (out_en_q & ~out_acc) : '0;

    assign accepted_all = in_acc_all & out_acc_all;
    assign done_all     = in_dn_all & out_dn_all & eng_dn_all;

    mmul_parallel_sticky_flags #(.WIDTH(N_IN)) u_in_acc (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .clr     (flags_clr),
        .set     (in_req_o & in_ready_i),
        .mask    (in_en_q),
        .flags   (in_acc),
        .all_set (in_acc_all)
    );

    mmul_parallel_sticky_flags #(.WIDTH(N_OUT)) u_out_acc (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .clr     (flags_clr),
        .set     (out_req_o & out_ready_i),
        .mask    (out_en_q),
        .flags   (out_acc),
        .all_set (out_acc_all)
    );

    mmul_parallel_sticky_flags #(.WIDTH(N_IN)) u_in_done (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .clr     (flags_clr),
        .set     (collect ? in_done_i : '0),
        .mask    (in_en_q),
        .flags   (unused_in_dn),
        .all_set (in_dn_all)
    );

    mmul_parallel_sticky_flags #(.WIDTH(N_OUT)) u_out_done (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .clr     (flags_clr),
        .set     (collect ? out_done_i : '0),
        .mask    (out_en_q),
        .flags   (unused_out_dn),
        .all_set (out_dn_all)
    );

    mmul_parallel_sticky_flags #(.WIDTH(1)) u_eng_done (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .clr     (flags_clr),
        .set     (collect & eng_done_i),
        .mask    (1'b1),
        .flags   (unused_eng_dn),
        .all_set (eng_dn_all)
    );

    always_comb begin
        state_d     = state_q;
        flags_clr   = 1'b0;
        iter_clr    = 1'b0;
        iter_inc    = 1'b0;
        job_start   = 1'b0;
        eng_start_o = 1'b0;
        done_evt_o  = 1'b0;
        if (clear_i) begin
            // Abort wins over everything, including a pending completion event.
            state_d   = ST_IDLE;
            flags_clr = 1'b1;
            iter_clr  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    flags_clr = 1'b1;
                    if (start_i) begin
                        job_start = 1'b1;
                        state_d   = ST_REQUEST;
                    end
                end
                ST_REQUEST: begin
                    if (accepted_all) begin
                        eng_start_o = 1'b1;
                        state_d     = ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    if (done_all) begin
                        flags_clr = 1'b1;
                        // Compare before incrementing so an all-ones limit
                        // terminates without the counter ever wrapping.
                        if (iter_q == limit_q) begin
                            state_d = ST_TERMINATE;
                        end else begin
                            iter_inc = 1'b1;
                            state_d  = ST_REQUEST;
                        end
                    end
                end
                ST_TERMINATE: begin
                    done_evt_o = 1'b1;
                    flags_clr  = 1'b1;
                    iter_clr   = 1'b1;
                    state_d    = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            iter_q   <= '0;
            limit_q  <= '0;
            in_en_q  <= '0;
            out_en_q <= '0;
        end else begin
            state_q <= state_d;
            if (iter_clr) begin
                iter_q <= '0;
            end else if (iter_inc) begin
                iter_q <= iter_q + CNT_W'(1);
            end
            if (job_start) begin
                limit_q  <= cnt_limit_i;
                in_en_q  <= in_en_i;
                out_en_q <= out_en_i;
            end
        end
    end

    assign busy_o = req_phase || (state_q == ST_COMPUTE);
    assign iter_o = iter_q;

endmodule

// File: tb/tb_mmul_parallel_job_seq.sv
// tb/tb_mmul_parallel_job_seq.sv - self-checking bench for the parallel job sequencer
module tb_mmul_parallel_job_seq;

    localparam int N_IN  = 2;
    localparam int N_OUT = 1;
    localparam int CNT_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             clear_i;
    logic             start_i;
    logic [CNT_W-1:0] cnt_limit_i;
    logic [N_IN-1:0]  in_en_i;
    logic [N_OUT-1:0] out_en_i;
    logic [N_IN-1:0]  in_req_o;
    logic [N_IN-1:0]  in_ready_i;
    logic [N_IN-1:0]  in_done_i;
    logic [N_OUT-1:0] out_req_o;
    logic [N_OUT-1:0] out_ready_i;
    logic [N_OUT-1:0] out_done_i;
    logic             eng_start_o;
    logic             eng_done_i;
    logic             busy_o;
    logic             done_evt_o;
    logic [CNT_W-1:0] iter_o;

    mmul_parallel_job_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .CNT_W(CNT_W)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .start_i     (start_i),
        .cnt_limit_i (cnt_limit_i),
        .in_en_i     (in_en_i),
        .out_en_i    (out_en_i),
        .in_req_o    (in_req_o),
        .in_ready_i  (in_ready_i),
        .in_done_i   (in_done_i),
        .out_req_o   (out_req_o),
        .out_ready_i (out_ready_i),
        .out_done_i  (out_done_i),
        .eng_start_o (eng_start_o),
        .eng_done_i  (eng_done_i),
        .busy_o      (busy_o),
        .done_evt_o  (done_evt_o),
        .iter_o      (iter_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int         lim;
        logic [1:0] in_en;
        logic       out_en;
        int         rdy;        // 0: random 1..3 cycles, else fixed cycles
        int         dly;        // cycles from eng_start to the done strobes
        bit         poke;       // fire stray start_i pulses while busy
        int         exp_starts; // expected engine start pulses
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick_rdy(input int r);
        return (r == 0) ? int'($urandom_range(0, 2)) : r - 1;
    endfunction

    task automatic quiet_inputs();
        in_ready_i  = '0;
        out_ready_i = '0;
        in_done_i   = '0;
        out_done_i  = '0;
        eng_done_i  = 1'b0;
        start_i     = 1'b0;
    endtask

    // Reference model: a job is a series of iterations; each iteration
    // requests every enabled stream, starts the engine in the first cycle
    // that all enabled streams have been accepted, waits for all dones,
    // and two cycles after the last done either restarts requesting or
    // raises the completion event.
    task automatic run_job(input vec_t v);
        logic [1:0] ei, acc;
        logic       eo, acc_o, exp_start;
        int         rd[3];
        int         phase, timer, it, nst, nev;
        ei = v.in_en;
        eo = v.out_en;
        @(negedge clk_i);
        quiet_inputs();
        cnt_limit_i = CNT_W'(v.lim);
        in_en_i     = ei;
        out_en_i    = eo;
        start_i     = 1'b1;
        @(negedge clk_i);
        start_i     = 1'b0;
        cnt_limit_i = CNT_W'($urandom);
        in_en_i     = 2'($urandom);
        out_en_i    = 1'($urandom);
        phase = 0; acc = '0; acc_o = 1'b0; it = 0; nst = 0; nev = 0; timer = 0;
        for (int k = 0; k < 3; k++) rd[k] = pick_rdy(v.rdy);
        for (int c = 0; c < 3000 && phase != 4; c++) begin
            exp_start = (phase == 0) && ((acc | ~ei) == 2'b11) && (acc_o | ~eo);
            chk("in_req", 32'(in_req_o), 32'((phase == 0) ? (ei & ~acc) : 2'b00));
            chk("out_req", 32'(out_req_o), 32'((phase == 0) ? (eo & ~acc_o) : 1'b0));
            chk("eng_start", 32'(eng_start_o), 32'(exp_start));
            chk("busy", 32'(busy_o), 32'(phase < 3));
            chk("done_evt", 32'(done_evt_o), 32'(phase == 3));
            chk("iter", 32'(iter_o), 32'(it));
            if (eng_start_o) nst++;
            if (done_evt_o) nev++;
            quiet_inputs();
            for (int k = 0; k < N_IN; k++)
                if (!ei[k]) in_ready_i[k] = 1'($urandom_range(0, 1));
            if (!eo) out_ready_i[0] = 1'($urandom_range(0, 1));
            if (v.poke && phase < 3 && $urandom_range(0, 2) == 0) begin
                start_i     = 1'b1;
                cnt_limit_i = CNT_W'($urandom);
                in_en_i     = 2'($urandom);
            end
            case (phase)
                0: begin
                    if (exp_start) begin
                        phase = 1;
                        timer = v.dly;
                    end else begin
                        for (int k = 0; k < N_IN; k++) begin
                            if (ei[k] && !acc[k]) begin
                                if (rd[k] == 0) begin
                                    in_ready_i[k] = 1'b1;
                                    acc[k] = 1'b1;
                                end else begin
                                    rd[k]--;
                                end
                            end
                        end
                        if (eo && !acc_o) begin
                            if (rd[2] == 0) begin
                                out_ready_i[0] = 1'b1;
                                acc_o = 1'b1;
                            end else begin
                                rd[2]--;
                            end
                        end
                    end
                end
                2: begin
                    if (it == v.lim) begin
                        phase = 3;
                    end else begin
                        it++;
                        phase = 0;
                        acc = '0;
                        acc_o = 1'b0;
                        for (int k = 0; k < 3; k++) rd[k] = pick_rdy(v.rdy);
                    end
                end
                3: phase = 4;
                default: ;
            endcase
            if (phase == 1) begin
                if (timer == 0) begin
                    in_done_i  = ei;
                    out_done_i = eo;
                    eng_done_i = 1'b1;
                    phase = 2;
                end else begin
                    timer--;
                end
            end
            @(negedge clk_i);
        end
        quiet_inputs();
        chk("job_timeout", 32'(phase), 32'd4);
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_iter", 32'(iter_o), 32'd0);
        chk("idle_evt", 32'(done_evt_o), 32'd0);
        chk("idle_req", 32'({in_req_o, out_req_o}), 32'd0);
        chk("start_pulses_tbl", 32'(nst), 32'(v.exp_starts));
        chk("start_pulses_model", 32'(nst), 32'(v.lim + 1));
        chk("done_events", 32'(nev), 32'd1);
    endtask

    task automatic watch_no_evt(input int cycles, input string name);
        int evc;
        evc = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk_i);
            if (done_evt_o || busy_o) evc++;
        end
        chk(name, 32'(evc), 32'd0);
    endtask

    vec_t tbl[5];
    vec_t rv;

    initial begin
        rst_ni      = 1'b0;
        clear_i     = 1'b0;
        cnt_limit_i = '0;
        in_en_i     = '0;
        out_en_i    = '0;
        quiet_inputs();

        #12;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_iter", 32'(iter_o), 32'd0);
        chk("rst_req", 32'({in_req_o, out_req_o}), 32'd0);
        chk("rst_eng_start", 32'(eng_start_o), 32'd0);
        chk("rst_evt", 32'(done_evt_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        tbl[0] = '{lim: 2,  in_en: 2'b11, out_en: 1'b1, rdy: 0, dly: 10, poke: 1'b0, exp_starts: 3};
        tbl[1] = '{lim: 0,  in_en: 2'b01, out_en: 1'b1, rdy: 2, dly: 3,  poke: 1'b0, exp_starts: 1};
        tbl[2] = '{lim: 1,  in_en: 2'b00, out_en: 1'b0, rdy: 1, dly: 2,  poke: 1'b0, exp_starts: 2};
        tbl[3] = '{lim: 15, in_en: 2'b11, out_en: 1'b1, rdy: 1, dly: 1,  poke: 1'b1, exp_starts: 16};
        tbl[4] = '{lim: 3,  in_en: 2'b10, out_en: 1'b0, rdy: 3, dly: 0,  poke: 1'b1, exp_starts: 4};
        for (int i = 0; i < 5; i++) run_job(tbl[i]);

        // A done that arrives before the engine is started must be kept.
        @(negedge clk_i);
        cnt_limit_i = '0; in_en_i = 2'b11; out_en_i = 1'b1; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("early_req", 32'(in_req_o), 32'd3);
        in_done_i = 2'b10;
        @(negedge clk_i);
        in_done_i = '0;
        chk("early_no_start", 32'(eng_start_o), 32'd0);
        in_ready_i = 2'b11; out_ready_i = 1'b1;
        @(negedge clk_i);
        in_ready_i = '0; out_ready_i = '0;
        chk("early_start", 32'(eng_start_o), 32'd1);
        @(negedge clk_i);
        chk("early_compute_busy", 32'(busy_o), 32'd1);
        in_done_i = 2'b01; out_done_i = 1'b1; eng_done_i = 1'b1;
        @(negedge clk_i);
        quiet_inputs();
        chk("early_evt_not_yet", 32'(done_evt_o), 32'd0);
        @(negedge clk_i);
        chk("early_evt", 32'(done_evt_o), 32'd1);
        chk("early_term_busy", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        chk("early_evt_once", 32'(done_evt_o), 32'd0);

        // Soft clear while computing iteration 1.
        cnt_limit_i = 4'd3; in_en_i = 2'b11; out_en_i = 1'b1; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        in_ready_i = 2'b11; out_ready_i = 1'b1;
        @(negedge clk_i);
        in_ready_i = '0; out_ready_i = '0;
        chk("clr_start0", 32'(eng_start_o), 32'd1);
        in_done_i = 2'b11; out_done_i = 1'b1; eng_done_i = 1'b1;
        @(negedge clk_i);
        quiet_inputs();
        @(negedge clk_i);
        chk("clr_iter1", 32'(iter_o), 32'd1);
        in_ready_i = 2'b11; out_ready_i = 1'b1;
        @(negedge clk_i);
        in_ready_i = '0; out_ready_i = '0;
        chk("clr_start1", 32'(eng_start_o), 32'd1);
        @(negedge clk_i);
        chk("clr_compute_busy", 32'(busy_o), 32'd1);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        chk("clr_busy", 32'(busy_o), 32'd0);
        chk("clr_iter", 32'(iter_o), 32'd0);
        chk("clr_evt", 32'(done_evt_o), 32'd0);
        watch_no_evt(20, "clr_silent");
        clear_i = 1'b1; start_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0; start_i = 1'b0;
        chk("clr_over_start", 32'(busy_o), 32'd0);
        run_job(tbl[0]);

        // Reset in the middle of a job aborts it without an event.
        @(negedge clk_i);
        cnt_limit_i = 4'd2; in_en_i = 2'b11; out_en_i = 1'b1; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("mid_rst_req_before", 32'(in_req_o), 32'd3);
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_rst_req", 32'({in_req_o, out_req_o}), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        watch_no_evt(20, "mid_rst_silent");

        for (int i = 0; i < 6; i++) begin
            rv.lim        = int'($urandom_range(0, 5));
            rv.in_en      = 2'($urandom);
            rv.out_en     = 1'($urandom);
            rv.rdy        = 0;
            rv.dly        = int'($urandom_range(0, 6));
            rv.poke       = 1'($urandom);
            rv.exp_starts = rv.lim + 1;
            run_job(rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
